// File: rtl/ula_pkg.sv
// Shared opcode, FSM state and iterative-unit mode encodings for the ULA.
package ula_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_NAND = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_CMP  = 4'd8,
    OP_NOTA = 4'd9,
    OP_NOTB = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  typedef enum logic {
    MD_MUL,
    MD_DIV
  } md_mode_e;

endpackage

// File: rtl/ula.sv
// Combinational single-cycle ALU; MUL/DIV produce 0 here except divide-by-zero.
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             dbz
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    dbz   = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        res   = a - b;
        carry = (a < b);
      end
      OP_DIV: begin
        if (b == '0) begin
          res = '1;
          dbz = 1'b1;
        end
      end
      OP_AND:  res = a & b;
      OP_NAND: res = ~(a & b);
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_CMP: begin
        if (a > b)      res = WIDTH'(1);
        else if (a < b) res = '1;
      end
      OP_NOTA: res = ~a;
      OP_NOTB: res = ~b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/ula_iter_md.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
module ula_iter_md
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_mode_e         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finished,
  output logic [WIDTH-1:0] result,
  output logic             high_nz
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc, sr, opr, acc_n, sr_n, addend;
  logic [WIDTH:0]   sum, sh, diff;
  logic [CW-1:0]    cnt;
  logic             run;
  md_mode_e         md;

  // acc holds the product high half (MUL) or the partial remainder (DIV);
  // sr holds the multiplier/product low half or the dividend/quotient.
  always_comb begin
    addend = sr[0] ? opr : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
    sh     = {acc, sr[WIDTH-1]};
    diff   = sh - {1'b0, opr};
    acc_n  = acc;
    sr_n   = sr;
    if (md == MD_MUL) begin
      acc_n = sum[WIDTH:1];
      sr_n  = {sum[0], sr[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_n = diff[WIDTH-1:0];
      sr_n  = {sr[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = sh[WIDTH-1:0];
      sr_n  = {sr[WIDTH-2:0], 1'b0};
    end
  end

  // Result reflects the step being taken this cycle, so the caller can
  // capture it on the same edge as the final iteration.
  assign finished = run && (cnt == CW'(1));
  assign result   = sr_n;
  assign high_nz  = (md == MD_MUL) && (acc_n != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sr  <= '0;
      opr <= '0;
      cnt <= '0;
      run <= 1'b0;
      md  <= MD_MUL;
    end else if (start) begin
      acc <= '0;
      sr  <= (mode == MD_DIV) ? a : b;
      opr <= (mode == MD_DIV) ? b : a;
      cnt <= CW'(WIDTH);
      run <= 1'b1;
      md  <= mode;
    end else if (run) begin
      acc <= acc_n;
      sr  <= sr_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle ops via ula, MUL/DIV via ula_iter_md.
module ula_mc
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             DivByZero
);

  state_e           state, state_n;
  logic             accept, iterative, md_fin, md_hi, alu_c, alu_dbz;
  logic [WIDTH-1:0] md_res, alu_res;
  md_mode_e         md_mode;

  assign accept    = start && (state == S_IDLE);
  assign iterative = (ALU_Sel == OP_MUL) || ((ALU_Sel == OP_DIV) && (B != '0));
  assign md_mode   = (ALU_Sel == OP_DIV) ? MD_DIV : MD_MUL;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  ula #(.WIDTH(WIDTH)) u_ula (
    .a     (A),
    .b     (B),
    .op    (ALU_Sel),
    .res   (alu_res),
    .carry (alu_c),
    .dbz   (alu_dbz)
  );

  ula_iter_md #(.WIDTH(WIDTH)) u_md (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && iterative),
    .mode     (md_mode),
    .a        (A),
    .b        (B),
    .finished (md_fin),
    .result   (md_res),
    .high_nz  (md_hi)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (ALU_Sel == OP_MUL) state_n = S_MUL;
          else if (iterative)    state_n = S_DIV;
          else                   state_n = S_DONE;
        end
      end
      S_MUL, S_DIV: if (md_fin) state_n = S_DONE;
      S_DONE:       state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ALU_Out   <= '0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !iterative) begin
        ALU_Out   <= alu_res;
        CarryOut  <= alu_c;
        Zero      <= (alu_res == '0);
        DivByZero <= alu_dbz;
      end else if (md_fin) begin
        ALU_Out   <= md_res;
        CarryOut  <= md_hi;
        Zero      <= (md_res == '0);
        DivByZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_mc.sv
// Bench for ula_mc: directed literal cases plus randomized traffic vs a behavioural model.
module tb_ula_mc;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   ALU_Sel = '0;
  logic         busy, done, CarryOut, Zero, DivByZero;
  logic [W-1:0] ALU_Out;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ula_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .busy      (busy),
    .done      (done),
    .ALU_Out   (ALU_Out),
    .CarryOut  (CarryOut),
    .Zero      (Zero),
    .DivByZero (DivByZero)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the opcode table.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int r, output int c, output int d, output int lat);
    int full;
    r = 0; c = 0; d = 0; lat = 1;
    case (op)
      0: begin full = a + b; r = full & MASK; c = (full >> W) & 1; end
      1: begin r = (a - b) & MASK; c = (a < b) ? 1 : 0; end
      2: begin full = a * b; r = full & MASK; c = ((full >> W) != 0) ? 1 : 0; lat = W + 1; end
      3: begin
        if (b == 0) begin r = MASK; d = 1; end
        else begin r = a / b; lat = W + 1; end
      end
      4:  r = a & b;
      5:  r = ~(a & b) & MASK;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = (a > b) ? 1 : ((a < b) ? MASK : 0);
      9:  r = ~a & MASK;
      10: r = ~b & MASK;
      default: r = 0;
    endcase
  endfunction

  // Model: m_cnt = cycles remaining until idle; 1 means the done cycle.
  int m_cnt = 0, m_out = 0, m_c = 0, m_z = 0, m_d = 0;
  int p_out, p_c, p_d, m_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_out = 0; m_c = 0; m_z = 0; m_d = 0;
    end else if (m_cnt == 0) begin
      if (start) begin
        ref_op(int'(ALU_Sel), int'(A), int'(B), p_out, p_c, p_d, m_lat);
        m_cnt = m_lat;
        if (m_lat == 1) begin
          m_out = p_out; m_c = p_c; m_d = p_d; m_z = (p_out == 0) ? 1 : 0;
        end
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_out = p_out; m_c = p_c; m_d = p_d; m_z = (p_out == 0) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("busy",      busy,      (m_cnt != 0) ? 1 : 0);
      chk("done",      done,      (m_cnt == 1) ? 1 : 0);
      chk("ALU_Out",   ALU_Out,   m_out);
      chk("CarryOut",  CarryOut,  m_c);
      chk("Zero",      Zero,      m_z);
      chk("DivByZero", DivByZero, m_d);
    end
  end

  // Issue one op at a negedge, scramble inputs after accept, measure latency.
  task automatic op_check(input string n, input int sel, input int a, input int b,
                          input int eo, input int ec, input int ez, input int ed, input int el);
    int lat;
    ALU_Sel = 4'(sel); A = W'(a); B = W'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = W'($urandom); B = W'($urandom); ALU_Sel = 4'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({n, ".latency"}, lat, el);
    chk({n, ".out"},     ALU_Out, eo);
    chk({n, ".carry"},   CarryOut, ec);
    chk({n, ".zero"},    Zero, ez);
    chk({n, ".dbz"},     DivByZero, ed);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra, lat;
    #2 rst = 1'b1;
    #1;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.out", ALU_Out, 0);
    chk("reset.flags", {CarryOut, Zero, DivByZero}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    op_check("add_200_100", 0, 200, 100, 44, 1, 0, 0, 1);
    op_check("mul_20_15",   2, 20, 15, 44, 1, 0, 0, 9);
    op_check("mul_12_10",   2, 12, 10, 120, 0, 0, 0, 9);
    op_check("div_200_7",   3, 200, 7, 28, 0, 0, 0, 9);
    op_check("div_5_0",     3, 5, 0, 255, 0, 0, 1, 1);
    op_check("sub_5_5",     1, 5, 5, 0, 0, 1, 0, 1);
    op_check("cmp_3_9",     8, 3, 9, 255, 0, 0, 0, 1);
    op_check("cmp_9_3",     8, 9, 3, 1, 0, 0, 0, 1);
    op_check("op13",        13, 77, 33, 0, 0, 1, 0, 1);
    op_check("div_7_200",   3, 7, 200, 0, 0, 1, 0, 9);
    op_check("sub_3_5",     1, 3, 5, 254, 1, 0, 0, 1);

    // Start during a running MUL must be ignored.
    ALU_Sel = 4'd2; A = 8'd20; B = 8'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    ALU_Sel = 4'd0; A = 8'd1; B = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ignore.latency", lat, 4);
    chk("busy_ignore.out", ALU_Out, 44);
    chk("busy_ignore.carry", CarryOut, 1);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("busy_ignore.extra_done", extra, 0);

    // Reset four cycles into a DIV aborts it.
    ALU_Sel = 4'd3; A = 8'd200; B = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.out", ALU_Out, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.flags", {CarryOut, Zero, DivByZero}, 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort.no_done", extra, 0);
    op_check("add_after_rst", 0, 1, 2, 3, 0, 0, 0, 1);

    // Randomized traffic, including starts while busy and operand churn.
    repeat (600) begin
      start   = ($urandom_range(0, 2) == 0);
      A       = W'($urandom);
      B       = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      ALU_Sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 3)) : 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ula_mc.md
ULA_MC -- requirements
Module: ula_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request pulse; operands and opcode sampled when start=1 and busy=0.
REQ-005 SHALL have ports A, B  input  WIDTH  unsigned operands.
REQ-006 SHALL have port ALU_Sel  input  4  opcode.
REQ-007 SHALL have port busy  output  1  high while an operation is in flight.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-009 SHALL have port ALU_Out  output  WIDTH  registered result, held until the next done.
REQ-010 SHALL have ports CarryOut, Zero, DivByZero  output  1 each  registered flags, updated only with done.

Function
REQ-011 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 NAND, 6 OR, 7 XOR, 8 CMP, 9 NOT A, 10 NOT B; 11-15 produce result 0.
REQ-012 FSM SHALL have states IDLE, MUL, DIV, DONE; IDLE->DONE for single-cycle opcodes, IDLE->MUL for opcode 2, IDLE->DIV for opcode 3 with B!=0, IDLE->DONE for DIV with B=0.
REQ-013 Single-cycle opcodes SHALL assert done exactly 1 cycle after the accepting edge (latency 1).
REQ-014 MUL SHALL be shift-add, one bit per cycle, done asserted WIDTH+1 cycles after accept; ALU_Out = low WIDTH bits of the 2*WIDTH product.
REQ-015 DIV SHALL be restoring, one quotient bit per cycle, done asserted WIDTH+1 cycles after accept; ALU_Out = floor(A/B).
REQ-016 DIV with B=0 SHALL give ALU_Out all ones, DivByZero=1, latency 1; DivByZero SHALL be 0 for every other result.
REQ-017 CarryOut SHALL be: ADD carry bit WIDTH of A+B; SUB 1 when A<B (borrow); MUL 1 when product high half nonzero; 0 otherwise.
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-019 CMP SHALL give 1 when A>B, all ones when A<B, 0 when equal.
REQ-020 Zero SHALL equal (ALU_Out==0) for the result being delivered.
REQ-021 busy SHALL be 1 from the cycle after accept through the cycle done is high, and 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored with no effect on the running operation or outputs.
REQ-023 start in the cycle after done (FSM back in IDLE) SHALL be accepted; back-to-back throughput is one op per latency+1 cycles.
REQ-024 Operand changes on A, B, ALU_Sel after accept SHALL not affect the in-flight result.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, busy=0, done=0, ALU_Out=0, CarryOut=0, Zero=0, DivByZero=0, irrespective of clk.
REQ-026 rst mid-MUL/DIV SHALL abort the operation with no done pulse; first start after rst release SHALL be accepted normally.

Structure
REQ-027 Opcode constants and the FSM state encoding SHALL live in shared package ula_pkg, also used by the combinational ula.
REQ-028 The iterative multiply/divide datapath (accumulator, shift register, bit counter) SHALL be a single sub-module ula_iter_md, parametrised by WIDTH, with start/mode inputs and a finished output.
REQ-029 Bit counter width SHALL be $clog2(WIDTH)+1; no combinational A*B or A/B operators in synthesised logic.

Verification (WIDTH=8)
REQ-030 ADD A=200 B=100 start -> done 1 cycle later, ALU_Out=44, CarryOut=1, Zero=0.
REQ-031 MUL A=20 B=15 -> done 9 cycles after accept, ALU_Out=44, CarryOut=1; MUL A=12 B=10 -> 120, CarryOut=0.
REQ-032 DIV A=200 B=7 -> done 9 cycles after accept, ALU_Out=28; DIV A=5 B=0 -> done after 1 cycle, ALU_Out=255, DivByZero=1.
REQ-033 SUB A=5 B=5 -> ALU_Out=0, Zero=1, CarryOut=0; CMP A=3 B=9 -> ALU_Out=255.
REQ-034 start ADD during a running MUL -> ignored; MUL result unchanged, exactly one done pulse.
REQ-035 rst asserted 4 cycles into DIV -> outputs 0 asynchronously, no done; following ADD A=1 B=2 -> ALU_Out=3.
